serial_alu: RTL

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/alu_pkg.sv | 19 +
 rtl/bitSlice.sv | 35 +++
 rtl/serial_alu.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: default width, opcodes and FSM states.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitSlice.sv
// One-bit ALU slice: full adder/subtractor plus bitwise logic, selected by cntrl.
module bitSlice
    import alu_pkg::*;
(
    input  logic       A,
    input  logic       B,
    input  logic [2:0] cntrl,
    input  logic       carryIn,
    output logic       out,
    output logic       carryOut
);

    logic bx;

    always_comb begin
        bx       = B ^ cntrl[0];   // subtract adds ~B with carry-in preset to 1
        out      = 1'b0;
        carryOut = 1'b0;
        case (cntrl)
            ALU_PASS_B: out = B;
            ALU_ADD, ALU_SUB: begin
                out      = A ^ bx ^ carryIn;
                carryOut = (A & bx) | (carryIn & (A ^ bx));
            end
            ALU_AND: out = A & B;
            ALU_OR:  out = A | B;
            ALU_XOR: out = A ^ B;
            default: begin
                out      = 1'b0;
                carryOut = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one bitSlice processes an operand pair LSB first over WIDTH cycles.
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] result_reg;
    logic             negative_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             carry_out_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             slice_out;
    logic             slice_cout;
    logic [WIDTH-1:0] result_next;
    logic             is_arith;
    logic             last_bit;

    bitSlice u_slice (
        .A        (a_reg[cnt_reg]),
        .B        (b_reg[cnt_reg]),
        .cntrl    (op_reg),
        .carryIn  (carry_reg),
        .out      (slice_out),
        .carryOut (slice_cout)
    );

    assign result_next = {slice_out, result_reg[WIDTH-1:1]};
    assign is_arith    = (op_reg == ALU_ADD) || (op_reg == ALU_SUB);
    assign last_bit    = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            result_reg    <= '0;
            negative_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            carry_out_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg         <= A;
                        b_reg         <= B;
                        op_reg        <= cntrl;
                        cnt_reg       <= '0;
                        carry_reg     <= cntrl[0];
                        result_reg    <= '0;
                        negative_reg  <= 1'b0;
                        zero_reg      <= 1'b0;
                        overflow_reg  <= 1'b0;
                        carry_out_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= slice_cout;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_bit) begin
                        // carry_reg here is the carry into the MSB, slice_cout the carry out of it
                        negative_reg  <= slice_out;
                        zero_reg      <= (result_next == '0);
                        carry_out_reg <= is_arith & slice_cout;
                        overflow_reg  <= is_arith & (carry_reg ^ slice_cout);
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign result    = result_reg;
    assign negative  = negative_reg;
    assign zero      = zero_reg;
    assign overflow  = overflow_reg;
    assign carry_out = carry_out_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
